pulse_sync_mc: RTL
==================

Name: pulse_sync_mc

Overview:
Multi-channel, handshake-based clock-domain-crossing pulse synchronizer. It carries single-cycle pulses from the i_clk domain to the o_clk domain for NUM_CH independent channels, for any ratio of the two clock frequencies. Each channel uses a toggle request with an acknowledge fed back to the source. A per-channel pending counter queues back-to-back source pulses so none are lost, up to MAX_PEND, with sticky overflow reporting beyond that. It sits wherever the design moves event strobes (interrupts, start/done, credits) between unrelated clocks.

Parameters:
NUM_CH, 1, number of independent pulse channels (>=1)
SYNC_STAGES, 2, flop stages in each synchronizer chain, both directions (>=2)
MAX_PEND, 3, max queued source pulses per channel beyond the one in flight (>=1)

Ports:
rst_n  input  1  reset for both domains; asynchronous, active-high (rst_n=1 resets)
i_clk  input  1  source clock
o_clk  input  1  destination clock
i_pulse  input  NUM_CH  source pulses, sampled on posedge i_clk, one per channel
i_ovf_clr  input  NUM_CH  i_clk domain; clears the matching i_ovf bit
i_busy  output  NUM_CH  i_clk domain; channel has a pulse in flight or queued
i_ovf  output  NUM_CH  i_clk domain; sticky flag, a pulse was dropped
o_pulse  output  NUM_CH  o_clk domain; one-o_clk-cycle output pulse per delivered event

Behaviour:
- Reset (rst_n=1, asynchronous): all flops in both domains clear to 0 (req, ack sync chain, req sync chain, edge-detect flop, pending counter, ovf). o_pulse=0, i_busy=0, i_ovf=0. Reset mid-operation discards the in-flight pulse and all queued pulses; no o_pulse is generated for them after release.
- Source state per channel (i_clk): req toggle flop; ack_s = ack after SYNC_STAGES i_clk flops; pend counter, width $clog2(MAX_PEND+1).
- Idle = (req == ack_s). Launch = toggle req.
- i_pulse while idle and pend==0: launch on that edge; pend stays 0.
- i_pulse while not idle, or while pend>0: pend += 1.
- Idle and pend>0 on the same edge: launch and pend -= 1. If i_pulse is also high on that edge, pend is unchanged.
- i_pulse when pend==MAX_PEND and no decrement on that edge: pulse dropped, pend holds, i_ovf set.
- i_ovf_clr clears i_ovf. If a set and a clear occur on the same edge, set wins.
- i_busy = !idle || pend!=0, combinational from flops.
- Destination per channel (o_clk): req passes through SYNC_STAGES flops to give req_d. A delay flop holds prev = req_d of the previous cycle.
- o_pulse = req_d ^ prev, high for exactly one o_clk cycle.
- Latency: o_pulse rises after SYNC_STAGES to SYNC_STAGES+1 o_clk edges following the req toggle.
- ack = req_d, returned to the source through SYNC_STAGES i_clk flops.
- Min spacing between launches on one channel is the full round trip, about (SYNC_STAGES+1)·(Ti+To). Consecutive o_pulses on a channel are therefore always separated by >=1 low cycle.
- Channels are fully independent: no shared state, no arbitration.
- The synchronizer flops are the only CDC path. No combinational logic precedes any sync chain; req and ack are driven directly from flops.

Decomposition:
- Package pulse_sync_pkg: SYNC_STAGES_MIN=2, and a function for the pending-counter width ($clog2(MAX_PEND+1)).
- Sub-module pulse_sync_ch: one channel (source FSM, pending counter, both sync chains, edge detect).
- Top pulse_sync_mc: generate loop of NUM_CH instances of pulse_sync_ch.

Test Plan:
1. Single pulse, NUM_CH=1, SYNC_STAGES=2, Ti=10ns, To=20ns: one i_pulse -> exactly one o_pulse within 3 o_clk edges. i_busy falls about 3 i_clk edges after the ack toggle.
2. Burst of 3 consecutive-cycle i_pulses, MAX_PEND=3 -> 3 o_pulses, each one o_clk wide and separated. pend peaks at 2. i_ovf stays 0.
3. Overflow, MAX_PEND=3: 6 consecutive i_pulses -> 4 o_pulses (1 in flight + 3 queued). i_ovf=1 after the 5th pulse. i_ovf_clr=1 -> i_ovf=0 on the next edge. Set and clear on the same edge -> i_ovf=1.
4. Clock swap (Ti=20/To=10, then Ti=10/To=20), 2 pulses each -> 2 o_pulses per phase, each exactly one o_clk cycle long.
5. Reset mid-flight: assert rst_n=1 while req has toggled and pend=2 -> all outputs 0 immediately. No o_pulse after release. The next i_pulse is delivered normally.
6. NUM_CH=4: pulses on ch0 and ch2 simultaneously, a burst on ch3 -> o_pulse appears only on channels 0, 2, 3 with the correct counts. ch1 stays 0 throughout.

Source files
------------

// File: rtl/pulse_sync_pkg.sv
// Shared constants and sizing helpers for the multi-channel pulse synchronizer.
package pulse_sync_pkg;

  localparam int SYNC_STAGES_MIN = 2;

  // Width of a counter that must hold 0..max_pend inclusive.
  function automatic int pend_width(input int max_pend);
    if (max_pend < 1) begin
      return 1;
    end else begin
      return $clog2(max_pend + 1);
    end
  endfunction

endpackage

// File: rtl/pulse_sync_ch.sv
// One channel of the toggle/acknowledge pulse synchronizer: source-side launch
// and pending queue, request/acknowledge sync chains, destination edge detect.
module pulse_sync_ch
  import pulse_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_PEND    = 3
) (
  input  logic rst_n,
  input  logic i_clk,
  input  logic o_clk,
  input  logic pulse_i,
  input  logic ovf_clr_i,
  output logic busy_o,
  output logic ovf_o,
  output logic pulse_o
);

  localparam int            PW       = pend_width(MAX_PEND);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PEND);
  localparam logic [PW-1:0] PEND_ONE = PW'(1);
  localparam logic [PW-1:0] PEND_NIL = PW'(0);

  logic                   req_q, req_d;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic [PW-1:0]          pend_q, pend_d;
  logic                   ovf_q, ovf_d;
  logic                   idle_s, launch_s, ovf_set_s;

  logic [SYNC_STAGES-1:0] req_sync_q;
  logic                   prev_q;
  logic                   req_dst_s;

  assign idle_s    = (req_q == ack_sync_q[SYNC_STAGES-1]);
  assign req_dst_s = req_sync_q[SYNC_STAGES-1];

  // Source launch decision, pending-queue update and overflow detection.
  always_comb begin
    launch_s  = 1'b0;
    pend_d    = pend_q;
    ovf_set_s = 1'b0;
    if (idle_s && (pend_q != PEND_NIL)) begin
      // A queued pulse launches; a simultaneous new pulse takes its slot.
      launch_s = 1'b1;
      if (pulse_i) begin
        pend_d = pend_q;
      end else begin
        pend_d = pend_q - PEND_ONE;
      end
    end else if (pulse_i) begin
      if (idle_s) begin
        launch_s = 1'b1;
      end else if (pend_q == PEND_MAX) begin
        ovf_set_s = 1'b1;
      end else begin
        pend_d = pend_q + PEND_ONE;
      end
    end else begin
      pend_d = pend_q;
    end
  end

  // Sticky overflow: a new drop outranks a clear on the same edge.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  assign req_d = req_q ^ launch_s;

  // Source-domain state: request toggle, acknowledge synchronizer, queue, overflow.
  always_ff @(posedge i_clk or posedge rst_n) begin
    if (rst_n) begin
      req_q      <= 1'b0;
      ack_sync_q <= {SYNC_STAGES{1'b0}};
      pend_q     <= PEND_NIL;
      ovf_q      <= 1'b0;
    end else begin
      req_q      <= req_d;
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], req_dst_s};
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
    end
  end

  // Destination-domain request synchronizer and edge-detect history.
  always_ff @(posedge o_clk or posedge rst_n) begin
    if (rst_n) begin
      req_sync_q <= {SYNC_STAGES{1'b0}};
      prev_q     <= 1'b0;
    end else begin
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req_q};
      prev_q     <= req_dst_s;
    end
  end

  assign busy_o  = (!idle_s) || (pend_q != PEND_NIL);
  assign ovf_o   = ovf_q;
  assign pulse_o = req_dst_s ^ prev_q;

endmodule

// File: rtl/pulse_sync_mc.sv
// Multi-channel pulse synchronizer: NUM_CH fully independent channels.
module pulse_sync_mc
  import pulse_sync_pkg::*;
#(
  parameter int NUM_CH      = 1,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_PEND    = 3
) (
  input  logic              rst_n,
  input  logic              i_clk,
  input  logic              o_clk,
  input  logic [NUM_CH-1:0] i_pulse,
  input  logic [NUM_CH-1:0] i_ovf_clr,
  output logic [NUM_CH-1:0] i_busy,
  output logic [NUM_CH-1:0] i_ovf,
  output logic [NUM_CH-1:0] o_pulse
);

  localparam int STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pulse_sync_ch #(
      .SYNC_STAGES (STAGES),
      .MAX_PEND    (MAX_PEND)
    ) u_ch (
      .rst_n     (rst_n),
      .i_clk     (i_clk),
      .o_clk     (o_clk),
      .pulse_i   (i_pulse[g]),
      .ovf_clr_i (i_ovf_clr[g]),
      .busy_o    (i_busy[g]),
      .ovf_o     (i_ovf[g]),
      .pulse_o   (o_pulse[g])
    );
  end

endmodule
